// File: rtl/ghash_mult_accum.sv
// GHASH engine: digit-serial GF(2^128) multiply-accumulate, Y = (Y ^ X) * H.
// Consumes DIGIT bits of the operand per cycle; streams the tag out on last.
module ghash_mult_accum #(
   parameter int DATA_WIDTH = 128,
   parameter int DIGIT = 8,
   parameter logic [DATA_WIDTH-1:0] POLY = 128'hE1000000000000000000000000000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] h_i,
   input  logic                  h_load_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_last_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_tag_o,
   output logic                  busy_o
);

   localparam int N = DATA_WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   if ((DATA_WIDTH != 128) || (DIGIT < 1) || (DIGIT > DATA_WIDTH) ||
       ((DATA_WIDTH % DIGIT) != 0)) begin : g_bad_param
      $error("ghash_mult_accum: unsupported DATA_WIDTH/DIGIT");
   end

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] h_q;
   logic [DATA_WIDTH-1:0] y_q;
   logic [DATA_WIDTH-1:0] z_q;
   logic [DATA_WIDTH-1:0] v_q;
   logic [DATA_WIDTH-1:0] a_q;
   logic [CW-1:0]         cnt;
   logic                  last_q;

   logic [DATA_WIDTH-1:0] z_n;
   logic [DATA_WIDTH-1:0] v_n;
   logic [DATA_WIDTH-1:0] a_n;
   logic                  accept;
   logic                  done;

   assign in_ready_o = rst && (state == IDLE);
   assign busy_o     = (state != IDLE);
   assign accept     = in_valid_i && in_ready_o;
   assign done       = (cnt == CNT_LAST);

   // One digit of the shift-and-add multiply, MSB of A first.
   always_comb begin
      z_n = z_q;
      v_n = v_q;
      for (int i = 0; i < DIGIT; i++) begin
         if (a_q[DATA_WIDTH-1-i]) z_n = z_n ^ v_n;
         v_n = (v_n >> 1) ^ (v_n[0] ? POLY : '0);
      end
      a_n = a_q << DIGIT;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         h_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         v_q         <= '0;
         a_q         <= '0;
         cnt         <= '0;
         last_q      <= 1'b0;
         out_valid_o <= 1'b0;
         out_tag_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (h_load_i) h_q <= h_i;
               // Block takes the H held before this edge.
               if (accept) begin
                  a_q    <= y_q ^ in_data_i;
                  z_q    <= '0;
                  v_q    <= h_q;
                  last_q <= in_last_i;
                  cnt    <= '0;
                  state  <= MUL;
               end
            end
            MUL: begin
               z_q <= z_n;
               v_q <= v_n;
               a_q <= a_n;
               cnt <= cnt + 1'b1;
               if (done) begin
                  y_q <= z_n;
                  if (last_q) begin
                     out_tag_o   <= z_n;
                     out_valid_o <= 1'b1;
                     state       <= OUT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            OUT: begin
               if (out_ready_i) begin
                  out_valid_o <= 1'b0;
                  y_q         <= '0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ghash_mult_accum.sv
// Bench for ghash_mult_accum: GCM vectors, protocol corners and random
// messages against a polynomial-arithmetic GF(2^128) reference.
module tb_ghash_mult_accum;

   localparam int W = 128;
   localparam int N = 16;
   localparam logic [W-1:0] TC2_H  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [W-1:0] TC2_X1 = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [W-1:0] TC2_X2 = 128'h00000000000000000000000000000080;
   localparam logic [W-1:0] TC2_Y1 = 128'h5e2ec746917062882c85b0685353deb7;
   localparam logic [W-1:0] TC2_T  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
   localparam logic [W-1:0] ID_X   = 128'h0123456789ABCDEFFEDCBA9876543210;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] h_i = '0;
   logic         h_load_i = 1'b0;
   logic         in_valid_i = 1'b0;
   logic [W-1:0] in_data_i = '0;
   logic         in_last_i = 1'b0;
   logic         out_ready_i = 1'b0;
   logic         in_ready_o;
   logic         out_valid_o;
   logic [W-1:0] out_tag_o;
   logic         busy_o;

   logic         iv1 = 1'b0;
   logic         ir1, ov1, busy1;
   logic [W-1:0] tag1;
   logic         iv128 = 1'b0;
   logic         ir128, ov128, busy128;
   logic [W-1:0] tag128;

   always #5 clk = ~clk;

   ghash_mult_accum #(.DATA_WIDTH(W), .DIGIT(8)) dut (
      .clk(clk), .rst(rst), .h_i(h_i), .h_load_i(h_load_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_data_i(in_data_i), .in_last_i(in_last_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_tag_o(out_tag_o), .busy_o(busy_o)
   );

   ghash_mult_accum #(.DATA_WIDTH(W), .DIGIT(1)) dut_d1 (
      .clk(clk), .rst(rst), .h_i(h_i), .h_load_i(h_load_i),
      .in_valid_i(iv1), .in_ready_o(ir1),
      .in_data_i(in_data_i), .in_last_i(in_last_i),
      .out_valid_o(ov1), .out_ready_i(1'b1),
      .out_tag_o(tag1), .busy_o(busy1)
   );

   ghash_mult_accum #(.DATA_WIDTH(W), .DIGIT(128)) dut_d128 (
      .clk(clk), .rst(rst), .h_i(h_i), .h_load_i(h_load_i),
      .in_valid_i(iv128), .in_ready_o(ir128),
      .in_data_i(in_data_i), .in_last_i(in_last_i),
      .out_valid_o(ov128), .out_ready_i(1'b1),
      .out_tag_o(tag128), .busy_o(busy128)
   );

   int  n_checks = 0;
   int  n_fail = 0;
   time last_hs = 0;
   time prev_hs = 0;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rev(input logic [W-1:0] a);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = a[W-1-i];
      return r;
   endfunction

   // Plain polynomial product mod x^128 + x^7 + x^2 + x + 1.
   function automatic logic [W-1:0] gmul(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic [2*W-2:0] p;
      logic [2*W-2:0] ra;
      logic [2*W-2:0] red;
      logic [W-1:0]   rb;
      ra  = {{(W-1){1'b0}}, rev(a)};
      rb  = rev(b);
      red = {{(W-1){1'b0}}, 128'h87};
      p   = '0;
      for (int i = 0; i < W; i++)
         if (rb[i]) p = p ^ (ra << i);
      for (int k = 2*W-2; k >= W; k--)
         if (p[k]) begin
            p[k] = 1'b0;
            p = p ^ (red << (k - W));
         end
      return rev(p[W-1:0]);
   endfunction

   function automatic logic [W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_h(input logic [W-1:0] h);
      h_i = h;
      h_load_i = 1'b1;
      tick();
      h_load_i = 1'b0;
      h_i = rnd128();
   endtask

   task automatic send_block(input logic [W-1:0] x, input logic last,
                             input logic ld, input logic [W-1:0] newh);
      int waitc;
      waitc = 0;
      in_valid_i = 1'b1;
      in_data_i = x;
      in_last_i = last;
      while (!in_ready_o && waitc < 400) begin
         tick();
         waitc++;
      end
      check("accept_ready", {127'b0, in_ready_o}, 1);
      if (ld) begin
         h_i = newh;
         h_load_i = 1'b1;
      end
      @(posedge clk);
      prev_hs = last_hs;
      last_hs = $time;
      #1;
      in_valid_i = 1'b0;
      h_load_i = 1'b0;
      in_data_i = rnd128();
      in_last_i = 1'($urandom);
      check("busy_after_accept", {127'b0, busy_o}, 1);
   endtask

   task automatic wait_tag(input logic [W-1:0] exp, input int stall,
                           input string tag);
      int c;
      c = 0;
      out_ready_i = 1'b0;
      while (!out_valid_o && c < 400) begin
         tick();
         c++;
      end
      check({tag, "_valid"}, {127'b0, out_valid_o}, 1);
      check({tag, "_latency"}, W'(c), W'(N));
      for (int s = 0; s < stall; s++) begin
         tick();
         check({tag, "_stall_tag"}, out_tag_o, exp);
         check({tag, "_stall_ready"}, {127'b0, in_ready_o}, 0);
      end
      check(tag, out_tag_o, exp);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      check({tag, "_drop"}, {127'b0, out_valid_o}, 0);
      check({tag, "_hold"}, out_tag_o, exp);
   endtask

   initial begin
      int lat1, lat8, lat128;
      logic [W-1:0] t1, t8, t128, hm, hn, x, y;
      int nb;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {127'b0, out_valid_o}, 0);
      check("rst_out_tag", out_tag_o, 0);
      check("rst_busy", {127'b0, busy_o}, 0);
      check("rst_in_ready", {127'b0, in_ready_o}, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("idle_in_ready", {127'b0, in_ready_o}, 1);

      load_h(128'h80000000000000000000000000000000);
      in_data_i = ID_X;
      in_last_i = 1'b1;
      in_valid_i = 1'b1;
      iv1 = 1'b1;
      iv128 = 1'b1;
      tick();
      in_valid_i = 1'b0;
      iv1 = 1'b0;
      iv128 = 1'b0;
      in_data_i = rnd128();
      lat1 = 0; lat8 = 0; lat128 = 0;
      t1 = '0; t8 = '0; t128 = '0;
      for (int c = 1; c <= 140; c++) begin
         tick();
         if (ov1 && lat1 == 0) begin lat1 = c; t1 = tag1; end
         if (out_valid_o && lat8 == 0) begin lat8 = c; t8 = out_tag_o; end
         if (ov128 && lat128 == 0) begin lat128 = c; t128 = tag128; end
      end
      check("ident_tag_d1", t1, ID_X);
      check("ident_tag_d8", t8, ID_X);
      check("ident_tag_d128", t128, ID_X);
      check("ident_lat_d1", W'(lat1), 128);
      check("ident_lat_d8", W'(lat8), W'(N));
      check("ident_lat_d128", W'(lat128), 1);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;

      load_h(128'h40000000000000000000000000000000);
      send_block(128'h1, 1'b1, 1'b0, '0);
      wait_tag(128'hE1000000000000000000000000000000, 0, "reduction");

      load_h(TC2_H);
      send_block(TC2_X1, 1'b1, 1'b0, '0);
      wait_tag(TC2_Y1, 0, "tc2_y1");

      send_block(TC2_X1, 1'b0, 1'b0, '0);
      send_block(TC2_X2, 1'b1, 1'b0, '0);
      check("b2b_spacing", W'(last_hs - prev_hs), W'((N + 1) * 10));
      wait_tag(TC2_T, 10, "tc2_stall");

      send_block(TC2_X1, 1'b0, 1'b0, '0);
      send_block(TC2_X2, 1'b1, 1'b0, '0);
      wait_tag(TC2_T, 0, "tc2_repeat");

      send_block(TC2_X1, 1'b0, 1'b0, '0);
      tick();
      h_i = rnd128();
      h_load_i = 1'b1;
      tick();
      h_load_i = 1'b0;
      send_block(TC2_X2, 1'b1, 1'b0, '0);
      wait_tag(TC2_T, 0, "hload_mul");

      hn = rnd128();
      send_block(TC2_X1, 1'b1, 1'b1, hn);
      wait_tag(TC2_Y1, 0, "hload_same_edge");
      x = rnd128();
      send_block(x, 1'b1, 1'b0, '0);
      wait_tag(gmul(x, hn), 0, "hload_next_msg");

      send_block(TC2_X1, 1'b0, 1'b0, '0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("midrst_out_valid", {127'b0, out_valid_o}, 0);
      check("midrst_out_tag", out_tag_o, 0);
      check("midrst_busy", {127'b0, busy_o}, 0);
      check("midrst_in_ready", {127'b0, in_ready_o}, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      load_h(TC2_H);
      send_block(TC2_X1, 1'b0, 1'b0, '0);
      send_block(TC2_X2, 1'b1, 1'b0, '0);
      wait_tag(TC2_T, 0, "midrst_tc2");

      for (int m = 0; m < 20; m++) begin
         hm = rnd128();
         load_h(hm);
         nb = $urandom_range(1, 4);
         y = '0;
         for (int b = 0; b < nb; b++) begin
            x = rnd128();
            y = gmul(y ^ x, hm);
            repeat ($urandom_range(0, 3)) tick();
            send_block(x, 1'(b == nb - 1), 1'b0, '0);
         end
         wait_tag(y, $urandom_range(0, 3), "random_msg");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ghash_mult_accum.md
Name: ghash_mult_accum

Overview:
- Iterative, parametrised GHASH engine for the AES-GCM datapath.
- Computes the running tag Y_i = (Y_{i-1} XOR X_i) * H in GF(2^128), using the GCM bit order and the reduction polynomial 0xE1 followed by 120 zero bits.
- Generalises the single-shot combinational multiplier into a digit-serial multiplier of DIGIT bits per cycle, with block accumulation and a valid/ready stream interface.
- Sits between the AES-CTR core and the tag-compare/output stage.

Parameters:
- DATA_WIDTH, 128: block/field width. Only 128 is supported.
- DIGIT, 8: operand bits consumed per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64, 128. Must divide DATA_WIDTH.
- POLY, 128'hE1000000000000000000000000000000: reduction constant XORed after a right shift.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset. Asserts asynchronously; deasserted synchronously by the reset-sync upstream.
- h_i  in  DATA_WIDTH  hash subkey H.
- h_load_i  in  1  captures h_i into the internal H register.
- in_valid_i  in  1  input block X valid.
- in_ready_o  out  1  block can be accepted.
- in_data_i  in  DATA_WIDTH  block X (AAD, ciphertext or length block).
- in_last_i  in  1  X is the final block of the message.
- out_valid_o  out  1  tag valid.
- out_ready_i  in  1  consumer accepts the tag.
- out_tag_o  out  DATA_WIDTH  final GHASH value.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Bit order:
  - Bit DATA_WIDTH-1 is the coefficient of x^0; bit 0 is the coefficient of x^127.
  - mulx(V) = (V>>1) XOR (V[0] ? POLY : 0).
- Reset (rst low): all of the following go to 0: state=IDLE, H, Y, Z, V, A, cycle counter, last flag, out_valid_o, out_tag_o, busy_o. in_ready_o is 0 while rst is low.
- Reset mid-operation: abandons the multiply and clears Y. No output is produced.
- H load:
  - h_load_i is honoured only in IDLE. H updates on that edge.
  - It is ignored in MUL and OUT.
  - If h_load_i and an input handshake occur on the same edge, the new H is captured, but the accepted block is multiplied by the old H.
- FSM state IDLE:
  - in_ready_o=1.
  - On in_valid_i && in_ready_o:
    - A <= Y XOR in_data_i
    - Z <= 0
    - V <= H
    - last <= in_last_i
    - cnt <= 0
    - go to MUL.
- FSM state MUL:
  - in_ready_o=0.
  - Each cycle processes DIGIT bits of A, MSB first. For each bit b, taken in order: if A[DATA_WIDTH-1] then Z ^= V; then V = mulx(V); A <<= 1. This is unrolled combinationally DIGIT times.
  - cnt increments each cycle.
  - On the cycle with cnt == DATA_WIDTH/DIGIT-1:
    - Y <= final Z.
    - If last: out_tag_o <= final Z, out_valid_o <= 1, go to OUT.
    - Else go to IDLE.
- FSM state OUT:
  - out_valid_o and out_tag_o are held stable until out_ready_i.
  - On the handshake: out_valid_o <= 0, Y <= 0, go to IDLE.
  - out_tag_o retains its value after the handshake.
  - in_ready_o=0.
- Latency: handshake at edge k, result in Y at edge k+N, where N=DATA_WIDTH/DIGIT. When last=1, out_valid_o is high from edge k+N.
- Throughput: one block per N+1 cycles. Back-to-back in_valid_i inserts exactly one IDLE cycle between blocks.
- Boundary cases:
  - DIGIT=DATA_WIDTH gives N=1: a single MUL cycle.
  - A message of exactly one block (in_last_i on the first block) gives tag = X*H.
  - in_data_i and in_last_i are sampled only on the handshake edge.
  - out_ready_i held high permanently means the OUT state lasts exactly one cycle.
  - in_valid_i asserted while not ready: the block is held by the producer. No drop or duplication.

Test Plan:
- Identity:
  - Stimulus: H=0x80000000000000000000000000000000, one last block X=0x0123456789ABCDEFFEDCBA9876543210.
  - Required: out_tag_o equals X.
  - Required: out_valid_o rises exactly N cycles after acceptance. Check at DIGIT=1, 8 and 128.
- Reduction:
  - Stimulus: H=0x40000000000000000000000000000000 (x), X=0x00000000000000000000000000000001 (x^127).
  - Required: tag=0xE1000000000000000000000000000000.
- GCM test case 2:
  - Stimulus: H=66e94bd4ef8a2c3b884cfa59ca342b2e; X1=0388dace60b6a392f328c2b971b2fe78; X2=00000000000000000000000000000080 with last.
  - Required: intermediate Y=5e2ec746917062882c85b0685353deb7; tag=f38cbb1ad69223dcc3457ae5b6b0f885.
- Backpressure:
  - Stimulus: hold out_ready_i=0 for 10 cycles, then issue the test-case-2 stream again.
  - Required: tag stable throughout the stall, in_ready_o=0 while stalled, and an identical tag on the second message, proving Y was cleared.
- Reset mid-MUL:
  - Stimulus: drop rst at cycle 3 of MUL.
  - Required: all outputs 0 immediately; after release, the test-case-2 message reproduces f38cbb1a...f885.
- H load rules:
  - Stimulus: h_load_i pulsed during MUL.
  - Required: ignored; the tag uses the old H.
  - Stimulus: h_load_i pulsed on the same edge as an input handshake.
  - Required: the current block uses the old H, and the next message uses the new H.
